// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with registered one-hot grant, ack-driven release
// and a wait-cycle timeout that revokes an unacknowledged grant.
module rr_arbiter_8 #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       gnt_ack,
  output logic [7:0] gnt,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [2:0] ptr, ptr_nxt;
  logic [2:0] gnt_idx, gnt_idx_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic [7:0] gnt_nxt;
  logic       gnt_valid_nxt;
  logic       timeout_nxt;
  logic       found;
  logic [2:0] sel_idx;
  logic [2:0] idx;

  // First requester at or after ptr, wrapping mod 8.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    idx     = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && req[idx]) begin
        found   = 1'b1;
        sel_idx = idx;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    gnt_idx_nxt   = gnt_idx;
    wait_nxt      = wait_cnt;
    gnt_nxt       = gnt;
    gnt_valid_nxt = gnt_valid;
    timeout_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt     = GRANT;
          gnt_idx_nxt   = sel_idx;
          gnt_nxt       = 8'b1 << sel_idx;
          gnt_valid_nxt = 1'b1;
          wait_nxt      = '0;
        end
      end
      GRANT: begin
        // Ack wins over a coincident timeout, so no pulse in that case.
        if (gnt_ack || (wait_cnt == WAIT_LAST)) begin
          state_nxt     = IDLE;
          gnt_nxt       = '0;
          gnt_valid_nxt = 1'b0;
          ptr_nxt       = gnt_idx + 3'd1;
          wait_nxt      = '0;
          timeout_nxt   = !gnt_ack;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_idx   <= '0;
      wait_cnt  <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      gnt_idx   <= gnt_idx_nxt;
      wait_cnt  <= wait_nxt;
      gnt       <= gnt_nxt;
      gnt_valid <= gnt_valid_nxt;
      timeout   <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8: reset, rotation, wrap, timeout, req
// changes during a grant, ack/timeout coincidence and asynchronous reset.
module tb_rr_arbiter_8;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       gnt_ack;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic       timeout;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  rr_arbiter_8 #(.TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt_ack   (gnt_ack),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic expect_out(input string tag, input logic [7:0] exp_gnt, input logic exp_to);
    check({tag, " gnt"}, 32'(gnt), 32'(exp_gnt));
    check({tag, " gnt_valid"}, 32'(gnt_valid), 32'(exp_gnt != 8'h00));
    check({tag, " timeout"}, 32'(timeout), 32'(exp_to));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] enc(input logic [7:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
    return r;
  endfunction

  initial begin
    rst = 1'b1; req = '0; gnt_ack = 1'b0;
    #12;
    expect_out("reset", 8'h00, 1'b0);
    rst = 1'b0;
    #1;

    // Single requester 0, ack, then ptr must be 1
    req = 8'h01;
    tick(); expect_out("r0 grant", 8'h01, 1'b0);
    check("r0 enc", 32'(enc(gnt)), 32'd0);
    gnt_ack = 1'b1; req = 8'h00;
    tick(); expect_out("r0 release", 8'h00, 1'b0);
    gnt_ack = 1'b0; req = 8'h03;
    tick(); expect_out("ptr1 grant", 8'h02, 1'b0);
    gnt_ack = 1'b1; req = 8'h00;
    tick(); expect_out("ptr1 release", 8'h00, 1'b0);
    gnt_ack = 1'b0;

    // Reset back to ptr=0, then full rotation with one idle bubble each
    #2 rst = 1'b1; #1 rst = 1'b0;
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      tick(); expect_out($sformatf("rot%0d grant", k), 8'(8'h01 << (k % 8)), 1'b0);
      check($sformatf("rot%0d enc", k), 32'(enc(gnt)), 32'(k % 8));
      gnt_ack = 1'b1;
      tick(); expect_out($sformatf("rot%0d bubble", k), 8'h00, 1'b0);
      gnt_ack = 1'b0;
    end
    // ptr is now 1
    req = 8'h81;
    tick(); expect_out("wrap hi", 8'h80, 1'b0);
    gnt_ack = 1'b1;
    tick(); expect_out("wrap hi rel", 8'h00, 1'b0);
    gnt_ack = 1'b0;
    tick(); expect_out("wrap lo", 8'h01, 1'b0);
    gnt_ack = 1'b1;
    tick(); gnt_ack = 1'b0;

    // Timeout on bit 3: held 15 cycles, then pulse, next search from 4
    req = 8'h08;
    tick(); expect_out("to hold0", 8'h08, 1'b0);
    for (int i = 1; i < 15; i++) begin
      tick(); expect_out($sformatf("to hold%0d", i), 8'h08, 1'b0);
    end
    tick(); expect_out("to revoke", 8'h00, 1'b1);
    req = 8'h18;
    tick(); expect_out("to next", 8'h10, 1'b0);
    gnt_ack = 1'b1;
    tick(); gnt_ack = 1'b0;

    // ptr=5: grant 5, then req changes mid-grant
    req = 8'h20;
    tick(); expect_out("stable0", 8'h20, 1'b0);
    req = 8'h04;
    tick(); expect_out("stable1", 8'h20, 1'b0);
    tick(); expect_out("stable2", 8'h20, 1'b0);
    gnt_ack = 1'b1; req = 8'h00;
    tick(); expect_out("stable rel", 8'h00, 1'b0);
    gnt_ack = 1'b0;

    // ptr=6: ack coincides with the last wait cycle -> no timeout pulse
    req = 8'h40;
    tick(); expect_out("coin grant", 8'h40, 1'b0);
    for (int i = 1; i < 15; i++) tick();
    expect_out("coin last", 8'h40, 1'b0);
    gnt_ack = 1'b1; req = 8'h00;
    tick(); expect_out("coin rel", 8'h00, 1'b0);

    // ptr=7: ack held high while idle is ignored; then wrap to ptr=0
    req = 8'h00;
    tick(); expect_out("idle ack", 8'h00, 1'b0);
    req = 8'h80;
    tick(); expect_out("ack idle grant", 8'h80, 1'b0);
    req = 8'h81;
    tick(); expect_out("ack idle rel", 8'h00, 1'b0);
    gnt_ack = 1'b0;
    tick(); expect_out("ptr wrap", 8'h01, 1'b0);
    gnt_ack = 1'b1; req = 8'h00;
    tick(); gnt_ack = 1'b0;

    // ptr=1: asynchronous reset mid-grant
    req = 8'h10;
    tick(); expect_out("ar grant", 8'h10, 1'b0);
    #2 rst = 1'b1;
    #1 expect_out("ar async", 8'h00, 1'b0);
    #1 rst = 1'b0;
    req = 8'h11;
    tick(); expect_out("ar next", 8'h01, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
